// File: rtl/pixel_bus_pkg.sv
// Shared definitions for the pixel-plotting bus: frame geometry, slave FSM encoding
// and the pixel-to-byte-address mapping used by master and slave.
package pixel_bus_pkg;

    localparam logic [31:0] BASE_ADDR = 32'h0800_0000;
    localparam int unsigned X_BITS    = 10;
    localparam int unsigned Y_BITS    = 9;
    localparam int unsigned X_MAX     = 640;
    localparam int unsigned Y_MAX     = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } bus_state_e;

    function automatic logic [31:0] pixel_addr(input logic [X_BITS-1:0] x,
                                               input logic [Y_BITS-1:0] y);
        return BASE_ADDR + 32'(x) + (32'(y) << X_BITS);
    endfunction

endpackage

// File: rtl/pixel_dpram.sv
// 8-bit frame store: one write port and two independent registered read ports.
// A read of the address being written in the same cycle returns the old data.
module pixel_dpram #(
    parameter int unsigned AW = 19
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [7:0]    rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [7:0]    rdata_b
);

    logic [7:0] mem [0:(2**AW)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read registers are reset; the array contents survive reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            rdata_a <= mem[raddr_a];
            rdata_b <= mem[raddr_b];
        end
    end

endmodule

// File: rtl/pixel_sram_responder.sv
// Bus slave for the pixel plotter: decodes (x,y) from the byte address, stores/returns
// 8-bit pixels with a fixed ack latency, and feeds the VGA scan-out read port.
module pixel_sram_responder #(
    parameter logic [31:0] BASE_ADDR   = pixel_bus_pkg::BASE_ADDR,
    parameter int unsigned X_BITS      = pixel_bus_pkg::X_BITS,
    parameter int unsigned Y_BITS      = pixel_bus_pkg::Y_BITS,
    parameter int unsigned X_MAX       = pixel_bus_pkg::X_MAX,
    parameter int unsigned Y_MAX       = pixel_bus_pkg::Y_MAX,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       bus_addr,
    input  logic [3:0]        bus_byte_enable,
    input  logic              bus_read,
    input  logic              bus_write,
    input  logic [31:0]       bus_write_data,
    output logic [31:0]       bus_read_data,
    output logic              bus_ack,
    input  logic [X_BITS-1:0] scan_x,
    input  logic [Y_BITS-1:0] scan_y,
    output logic [7:0]        scan_pixel,
    output logic [31:0]       write_count,
    output logic              err
);

    import pixel_bus_pkg::*;

    localparam int unsigned AW = X_BITS + Y_BITS;

    bus_state_e state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       capture;

    logic [AW-1:0] cap_idx_q;
    logic [7:0]    cap_data_q;
    logic          cap_be0_q;
    logic          cap_write_q;
    logic          cap_read_q;
    logic          cap_both_q;
    logic          cap_in_range_q;
    logic [31:0]   write_count_q, write_count_d;
    logic          err_q, err_d;

    logic [31:0]       off;
    logic [X_BITS-1:0] dec_x;
    logic [Y_BITS-1:0] dec_y;
    logic              dec_in_range;
    logic              ack;
    logic              commit;
    logic [AW-1:0]     bus_raddr;
    logic [7:0]        bus_rdata;
    logic              unused_bus_bits;

    assign unused_bus_bits = ^{bus_byte_enable[3:1], bus_write_data[31:8]};

    assign off          = bus_addr - BASE_ADDR;
    assign dec_x        = off[X_BITS-1:0];
    assign dec_y        = off[AW-1:X_BITS];
    assign dec_in_range = (off[31:AW] == '0) && (32'(dec_x) < X_MAX) && (32'(dec_y) < Y_MAX);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        capture    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus_read || bus_write) begin
                    capture    = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = (WAIT_STATES > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                if (wait_cnt_q == 4'(WAIT_STATES - 1)) begin
                    state_d = ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ACK: state_d = HOLD;
            HOLD: begin
                if (!bus_read && !bus_write) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack    = (state_q == ACK);
    assign commit = ack && cap_write_q && cap_in_range_q && cap_be0_q;

    always_comb begin
        write_count_d = write_count_q;
        err_d         = err_q;
        if (commit) begin
            write_count_d = write_count_q + 32'd1;
        end
        if (ack && (!cap_in_range_q || cap_both_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            cap_idx_q      <= '0;
            cap_data_q     <= '0;
            cap_be0_q      <= 1'b0;
            cap_write_q    <= 1'b0;
            cap_read_q     <= 1'b0;
            cap_both_q     <= 1'b0;
            cap_in_range_q <= 1'b0;
            write_count_q  <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            write_count_q <= write_count_d;
            err_q         <= err_d;
            if (capture) begin
                cap_idx_q      <= {dec_y, dec_x};
                cap_data_q     <= bus_write_data[7:0];
                cap_be0_q      <= bus_byte_enable[0];
                cap_write_q    <= bus_write;
                cap_read_q     <= bus_read && !bus_write;
                cap_both_q     <= bus_read && bus_write;
                cap_in_range_q <= dec_in_range;
            end
        end
    end

    // Present the live address while idle so the read data is ready even with no wait states.
    assign bus_raddr = (state_q == IDLE) ? {dec_y, dec_x} : cap_idx_q;

    pixel_dpram #(
        .AW (AW)
    ) u_dpram (
        .clock   (clock),
        .reset   (reset),
        .we      (commit),
        .waddr   (cap_idx_q),
        .wdata   (cap_data_q),
        .raddr_a (bus_raddr),
        .rdata_a (bus_rdata),
        .raddr_b ({scan_y, scan_x}),
        .rdata_b (scan_pixel)
    );

    assign bus_ack       = ack;
    assign bus_read_data = (ack && cap_read_q && cap_in_range_q) ? {24'b0, bus_rdata} : 32'b0;
    assign write_count   = write_count_q;
    assign err           = err_q;

endmodule
